// File: rtl/mc_req_arb_if.sv
// mc_req_arb_if: command bundle between the arbiter and the RAM sequencer.
// master = arbiter side, slave = sequencer side.
interface mc_req_arb_if #(
   parameter int ADDR_W = 32
) ();
   logic              mem_cmd_valid;
   logic [1:0]        mem_cmd;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic              mem_ack;

   modport master (
      output mem_cmd_valid,
      output mem_cmd,
      output mem_addr,
      input  mem_ready,
      input  mem_ack
   );

   modport slave (
      input  mem_cmd_valid,
      input  mem_cmd,
      input  mem_addr,
      output mem_ready,
      output mem_ack
   );
endinterface

// File: rtl/mc_req_arb.sv
// mc_req_arb: shares the RAM command port between CRT, DE and host.
// Define MC_ARB_AGE_EN to promote DE/host requests that wait AGE_MAX cycles.
module mc_req_arb #(
   parameter int ADDR_W  = 32,
   parameter int AGE_MAX = 64
) (
   input  logic              mclock,
   input  logic              reset_n,
   input  logic              crt_req,
   input  logic              crt_urgent,
   input  logic [ADDR_W-1:0] crt_addr,
   input  logic [3:0]        crt_pages,
   input  logic              de_req,
   input  logic [1:0]        de_cmd,
   input  logic [ADDR_W-1:0] de_addr,
   input  logic [3:0]        de_pages,
   input  logic              hst_req,
   input  logic [1:0]        hst_cmd,
   input  logic [ADDR_W-1:0] hst_addr,
   input  logic [3:0]        hst_pages,
   output logic              crt_gnt,
   output logic              de_gnt,
   output logic              hst_gnt,
   output logic              arb_busy,
   mc_req_arb_if.master      mem
);

   typedef enum logic [1:0] {IDLE, ISSUE, BURST, TURN} state_t;

   localparam logic [1:0] R_DE  = 2'd0;
   localparam logic [1:0] R_HST = 2'd1;
   localparam logic [1:0] R_CRT = 2'd2;

   state_t            state, state_nx;
   logic [1:0]        rr_ptr, p1, p2, win;
   logic [2:0]        req_v;
   logic              any_req, load, de_aged, hst_aged;
   logic [4:0]        page_cnt;
   logic [1:0]        sel_cmd;
   logic [ADDR_W-1:0] sel_addr;
   logic [3:0]        sel_pages;

   function automatic logic [1:0] rr_next(input logic [1:0] p);
      return (p == R_CRT) ? R_DE : p + 2'd1;
   endfunction

`ifdef MC_ARB_AGE_EN
   logic [6:0] de_age, hst_age;

   assign de_aged  = de_req  && (de_age  >= 7'(AGE_MAX));
   assign hst_aged = hst_req && (hst_age >= 7'(AGE_MAX));

   // Saturating wait counters; cleared on the edge that grants the owner.
   always_ff @(posedge mclock or negedge reset_n) begin
      if (!reset_n) begin
         de_age  <= '0;
         hst_age <= '0;
      end else begin
         if (load && win == R_DE)
            de_age <= '0;
         else if (de_req && !de_gnt && de_age != 7'h7f)
            de_age <= de_age + 7'd1;
         if (load && win == R_HST)
            hst_age <= '0;
         else if (hst_req && !hst_gnt && hst_age != 7'h7f)
            hst_age <= hst_age + 7'd1;
      end
   end
`else
   localparam int unused_age_max = AGE_MAX;
   assign de_aged  = 1'b0;
   assign hst_aged = 1'b0;
`endif

   always_comb begin
      req_v   = {crt_req, hst_req, de_req};
      any_req = |req_v;
      p1      = rr_next(rr_ptr);
      p2      = rr_next(p1);
      if (crt_req && crt_urgent) win = R_CRT;
      else if (de_aged)          win = R_DE;
      else if (hst_aged)         win = R_HST;
      else if (req_v[rr_ptr])    win = rr_ptr;
      else if (req_v[p1])        win = p1;
      else                       win = p2;
   end

   always_comb begin
      sel_cmd   = 2'd1;
      sel_addr  = crt_addr;
      sel_pages = crt_pages;
      unique case (win)
         R_DE: begin
            sel_cmd   = (de_cmd == 2'd3) ? 2'd1 : de_cmd;
            sel_addr  = de_addr;
            sel_pages = de_pages;
         end
         R_HST: begin
            sel_cmd   = (hst_cmd == 2'd3) ? 2'd1 : hst_cmd;
            sel_addr  = hst_addr;
            sel_pages = hst_pages;
         end
         default: ;
      endcase
   end

   always_ff @(posedge mclock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx          = state;
      load              = 1'b0;
      mem.mem_cmd_valid = 1'b0;
      arb_busy          = 1'b1;
      unique case (state)
         IDLE: begin
            arb_busy = 1'b0;
            if (any_req) begin
               load     = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            mem.mem_cmd_valid = 1'b1;
            if (mem.mem_ready) state_nx = BURST;
         end
         BURST: begin
            if (mem.mem_ack && page_cnt == 5'd1) state_nx = TURN;
         end
         TURN:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge mclock or negedge reset_n) begin
      if (!reset_n) begin
         crt_gnt      <= 1'b0;
         de_gnt       <= 1'b0;
         hst_gnt      <= 1'b0;
         mem.mem_cmd  <= '0;
         mem.mem_addr <= '0;
         page_cnt     <= '0;
         rr_ptr       <= R_DE;
      end else if (load) begin
         de_gnt       <= (win == R_DE);
         hst_gnt      <= (win == R_HST);
         crt_gnt      <= (win == R_CRT);
         mem.mem_cmd  <= sel_cmd;
         mem.mem_addr <= sel_addr;
         page_cnt     <= {1'b0, sel_pages} + 5'd1;
         rr_ptr       <= rr_next(win);
      end else if (state == BURST && mem.mem_ack && page_cnt != 5'd0) begin
         page_cnt <= page_cnt - 5'd1;
         if (page_cnt == 5'd1) begin
            crt_gnt <= 1'b0;
            de_gnt  <= 1'b0;
            hst_gnt <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mc_req_arb.sv
// tb_mc_req_arb: directed vectors, corner sequences and a random run
// checked against a transaction-level arbitration model.
module tb_mc_req_arb;
   localparam int AW  = 32;
   localparam int AGE = 64;

   logic          mclock = 1'b0;
   logic          reset_n = 1'b0;
   logic          crt_req, crt_urgent, de_req, hst_req;
   logic [AW-1:0] crt_addr, de_addr, hst_addr;
   logic [3:0]    crt_pages, de_pages, hst_pages;
   logic [1:0]    de_cmd, hst_cmd;
   logic          crt_gnt, de_gnt, hst_gnt, arb_busy;

   mc_req_arb_if #(.ADDR_W(AW)) mem ();

   mc_req_arb #(.ADDR_W(AW), .AGE_MAX(AGE)) dut (
      .mclock     (mclock),
      .reset_n    (reset_n),
      .crt_req    (crt_req),
      .crt_urgent (crt_urgent),
      .crt_addr   (crt_addr),
      .crt_pages  (crt_pages),
      .de_req     (de_req),
      .de_cmd     (de_cmd),
      .de_addr    (de_addr),
      .de_pages   (de_pages),
      .hst_req    (hst_req),
      .hst_cmd    (hst_cmd),
      .hst_addr   (hst_addr),
      .hst_pages  (hst_pages),
      .crt_gnt    (crt_gnt),
      .de_gnt     (de_gnt),
      .hst_gnt    (hst_gnt),
      .arb_busy   (arb_busy),
      .mem        (mem.master)
   );

   always #5 mclock = ~mclock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       de_req;
      logic       rdy;
      logic       ack;
      logic [2:0] e_gnt;
      logic       e_vld;
      logic       e_busy;
   } vec_t;
   vec_t tv[8];

   // Reference model state: who owns the port, what is left to do.
   int            m_ph, m_ptr, m_own, m_left, m_cmd;
   logic [AW-1:0] m_addr;
   int            m_age[2];

   int            ord[$];
   int            at[$];
   int            exp_ord[4];
   logic [2:0]    prev_g, cur_g, exp_g;
   logic [AW-1:0] hold_addr;
   bit            found;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge mclock);
      #1;
   endtask

   task automatic clear_inputs();
      crt_req = 0; crt_urgent = 0; crt_addr = '0; crt_pages = '0;
      de_req = 0;  de_cmd = '0;    de_addr = '0;  de_pages = '0;
      hst_req = 0; hst_cmd = '0;   hst_addr = '0; hst_pages = '0;
      mem.mem_ready = 0; mem.mem_ack = 0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge mclock);
      @(negedge mclock);
      reset_n = 1'b1;
   endtask

   task automatic model_reset();
      m_ph = 0; m_ptr = 0; m_own = -1; m_left = 0; m_cmd = 0;
      m_addr = '0; m_age[0] = 0; m_age[1] = 0;
   endtask

   // One clock edge of the arbitration rules, using the sampled inputs.
   task automatic model_edge();
      bit rq[3];
      int w, k;
      rq[0] = de_req; rq[1] = hst_req; rq[2] = crt_req;
      w = -1;
      if (m_ph == 0 && (rq[0] || rq[1] || rq[2])) begin
         if (crt_req && crt_urgent) w = 2;
`ifdef MC_ARB_AGE_EN
         else if (rq[0] && m_age[0] >= AGE) w = 0;
         else if (rq[1] && m_age[1] >= AGE) w = 1;
`endif
         else begin
            for (int i = 0; i < 3; i++) begin
               k = (m_ptr + i) % 3;
               if (w < 0 && rq[k]) w = k;
            end
         end
      end
`ifdef MC_ARB_AGE_EN
      for (int r = 0; r < 2; r++) begin
         if (w == r) m_age[r] = 0;
         else if (rq[r] && m_own != r && m_age[r] < 127) m_age[r]++;
      end
`endif
      case (m_ph)
         0: if (w >= 0) begin
            m_own = w;
            m_ptr = (w + 1) % 3;
            m_ph  = 1;
            if (w == 0) begin
               m_cmd = (de_cmd == 2'd3) ? 1 : int'(de_cmd);
               m_addr = de_addr; m_left = int'(de_pages) + 1;
            end else if (w == 1) begin
               m_cmd = (hst_cmd == 2'd3) ? 1 : int'(hst_cmd);
               m_addr = hst_addr; m_left = int'(hst_pages) + 1;
            end else begin
               m_cmd = 1; m_addr = crt_addr; m_left = int'(crt_pages) + 1;
            end
         end
         1: if (mem.mem_ready) m_ph = 2;
         2: if (mem.mem_ack) begin
            m_left--;
            if (m_left == 0) begin
               m_ph = 3;
               m_own = -1;
            end
         end
         default: m_ph = 0;
      endcase
   endtask

   initial begin
      clear_inputs();
      exp_ord = '{0, 1, 2, 0};

      // reset state
      do_reset();
      chk("rst_gnt", 64'({crt_gnt, hst_gnt, de_gnt}), 64'd0);
      chk("rst_vld", 64'(mem.mem_cmd_valid), 64'd0);
      chk("rst_busy", 64'(arb_busy), 64'd0);
      chk("rst_addr", 64'(mem.mem_addr), 64'd0);

      // single DE write, 4 pages
      tv[0] = '{1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1};
      tv[1] = '{1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1};
      tv[2] = '{1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b1};
      tv[3] = '{1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b1};
      tv[4] = '{1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b1};
      tv[5] = '{1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1};
      tv[6] = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0};
      tv[7] = '{1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0};
      de_cmd = 2'd0; de_addr = 32'h1000_0040; de_pages = 4'd3;
      for (int i = 0; i < 8; i++) begin
         de_req = tv[i].de_req;
         mem.mem_ready = tv[i].rdy;
         mem.mem_ack = tv[i].ack;
         step();
         chk($sformatf("t1_gnt[%0d]", i),
             64'({crt_gnt, hst_gnt, de_gnt}), 64'(tv[i].e_gnt));
         chk($sformatf("t1_vld[%0d]", i),
             64'(mem.mem_cmd_valid), 64'(tv[i].e_vld));
         chk($sformatf("t1_busy[%0d]", i), 64'(arb_busy), 64'(tv[i].e_busy));
         if (i == 0) begin
            chk("t1_cmd", 64'(mem.mem_cmd), 64'd0);
            chk("t1_addr", 64'(mem.mem_addr), 64'h1000_0040);
         end
      end

      // all three requesting, none urgent: DE, host, CRT, DE every 4 cycles
      do_reset();
      de_req = 1; hst_req = 1; crt_req = 1;
      mem.mem_ready = 1; mem.mem_ack = 1;
      prev_g = '0;
      ord.delete(); at.delete();
      for (int c = 0; c < 14; c++) begin
         step();
         cur_g = {crt_gnt, hst_gnt, de_gnt};
         if (cur_g != 3'b000 && prev_g == 3'b000) begin
            ord.push_back(cur_g == 3'b001 ? 0 : (cur_g == 3'b010 ? 1 : 2));
            at.push_back(c);
         end
         prev_g = cur_g;
      end
      chk("t2_grants", 64'(ord.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < ord.size()) begin
            chk($sformatf("t2_order[%0d]", i), 64'(ord[i]), 64'(exp_ord[i]));
            if (i > 0)
               chk($sformatf("t2_gap[%0d]", i), 64'(at[i] - at[i-1]), 64'd4);
         end
      end

      // urgent CRT during a host burst waits for the burst to end
      do_reset();
      hst_req = 1; hst_cmd = 2'd2; hst_addr = 32'h0000_2200; hst_pages = 4'd2;
      crt_addr = 32'h0000_8000;
      mem.mem_ready = 1;
      step();
      chk("t3_hgnt", 64'({crt_gnt, hst_gnt, de_gnt}), 64'b010);
      chk("t3_cmd", 64'(mem.mem_cmd), 64'd2);
      hst_req = 0;
      step();
      crt_req = 1; crt_urgent = 1; de_req = 1; mem.mem_ack = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("t3_hold[%0d]", i),
             64'({crt_gnt, hst_gnt, de_gnt}), 64'b010);
      end
      step();
      chk("t3_done", 64'({crt_gnt, hst_gnt, de_gnt}), 64'b000);
      chk("t3_turn", 64'(arb_busy), 64'd1);
      mem.mem_ack = 0;
      step();
      chk("t3_idle", 64'(arb_busy), 64'd0);
      step();
      chk("t3_crt", 64'({crt_gnt, hst_gnt, de_gnt}), 64'b100);
      chk("t3_crtcmd", 64'(mem.mem_cmd), 64'd1);
      chk("t3_crtaddr", 64'(mem.mem_addr), 64'h0000_8000);

      // ready held low in ISSUE: command stays put, later req edits ignored
      do_reset();
      de_req = 1; de_cmd = 2'd3; de_addr = 32'hCAFE_0000; de_pages = 4'd0;
      hold_addr = de_addr;
      step();
      de_req = 0; de_addr = 32'h0BAD_0000; de_cmd = 2'd0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         chk($sformatf("t4_vld[%0d]", i), 64'(mem.mem_cmd_valid), 64'd1);
         chk($sformatf("t4_addr[%0d]", i), 64'(mem.mem_addr), 64'(hold_addr));
         chk($sformatf("t4_cmd[%0d]", i), 64'(mem.mem_cmd), 64'd1);
      end
      mem.mem_ready = 1;
      step();
      chk("t4_drop", 64'(mem.mem_cmd_valid), 64'd0);
      chk("t4_gnt", 64'(de_gnt), 64'd1);

      // asynchronous reset in the middle of a 7-page burst
      do_reset();
      de_req = 1; de_addr = 32'h4000_0000; de_pages = 4'd6; mem.mem_ready = 1;
      step();
      de_req = 0;
      step();
      mem.mem_ack = 1;
      #2 reset_n = 1'b0;
      #1;
      chk("t5_gnt", 64'({crt_gnt, hst_gnt, de_gnt}), 64'd0);
      chk("t5_vld", 64'(mem.mem_cmd_valid), 64'd0);
      chk("t5_busy", 64'(arb_busy), 64'd0);
      chk("t5_addr", 64'(mem.mem_addr), 64'd0);
      @(negedge mclock);
      reset_n = 1'b1;
      mem.mem_ack = 0;
      de_req = 1; hst_req = 1; crt_req = 1;
      step();
      chk("t5_rr", 64'({crt_gnt, hst_gnt, de_gnt}), 64'b001);

      // host gets in while CRT streams non-urgent bursts
      do_reset();
      crt_req = 1; mem.mem_ready = 1; mem.mem_ack = 1;
      repeat (3) step();
      hst_req = 1;
      found = 0;
      for (int i = 0; i < AGE + 4 && !found; i++) begin
         step();
         if (hst_gnt) found = 1;
      end
      chk("t6_host_gnt", 64'(found), 64'd1);

      // random traffic against the model
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         step();
         model_edge();
         exp_g = (m_own < 0) ? 3'b000 : 3'(1 << m_own);
         chk("rnd_gnt", 64'({crt_gnt, hst_gnt, de_gnt}), 64'(exp_g));
         chk("rnd_vld", 64'(mem.mem_cmd_valid), 64'(m_ph == 1));
         chk("rnd_busy", 64'(arb_busy), 64'(m_ph != 0));
         if (m_ph == 1) begin
            chk("rnd_cmd", 64'(mem.mem_cmd), 64'(m_cmd));
            chk("rnd_addr", 64'(mem.mem_addr), 64'(m_addr));
         end
         if (de_gnt) de_req = 0;
         else if (!de_req && $urandom_range(0, 99) < 30) begin
            de_req = 1; de_cmd = 2'($urandom_range(0, 3));
            de_addr = $urandom; de_pages = 4'($urandom_range(0, 15));
         end else if (de_req && $urandom_range(0, 99) < 3) de_req = 0;
         if (hst_gnt) hst_req = 0;
         else if (!hst_req && $urandom_range(0, 99) < 30) begin
            hst_req = 1; hst_cmd = 2'($urandom_range(0, 3));
            hst_addr = $urandom; hst_pages = 4'($urandom_range(0, 15));
         end else if (hst_req && $urandom_range(0, 99) < 3) hst_req = 0;
         if (crt_gnt) crt_req = 0;
         else if (!crt_req && $urandom_range(0, 99) < 20) begin
            crt_req = 1; crt_addr = $urandom;
            crt_pages = 4'($urandom_range(0, 15));
         end
         crt_urgent = ($urandom_range(0, 99) < 25);
         mem.mem_ready = ($urandom_range(0, 99) < 60);
         mem.mem_ack = ($urandom_range(0, 99) < 50);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
